pulse_train_gen: RTL
====================

Name: pulse_train_gen

Overview:
Transmit-side companion to the push-button rising-edge detector. On a one-cycle start request it drives a clean, glitch-free train of N rectangular pulses on a single output line. Each pulse has a fixed high time and a fixed low time. The block stimulates, or emulates the source of, signals consumed by the edge-detect logic, and reports progress with busy and done.

Parameters:
HI_CYC, 4, clocks sig_out is held high per pulse (>=1, must fit in CNT_W bits)
LO_CYC, 4, clocks sig_out is held low after each pulse (>=1, must fit in CNT_W bits)
CNT_W, 8, width of the phase-length counter
NUM_W, 4, width of the pulse-count request

Ports:
clk  input  1  system clock, all flops rising-edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  one-cycle request to begin a train; sampled on clk rise
num_pulses  input  NUM_W  pulse count; sampled only when start is accepted
abort  input  1  terminate the train in progress
sig_out  output  1  generated pulse line, registered
busy  output  1  high while a train is in progress, registered
done  output  1  one-cycle completion pulse, registered

Behaviour:
- Clocking and reset: one clock, clk. Reset is rst_n, asynchronous and active-low. While rst_n=0: state=IDLE, sig_out=0, busy=0, done=0, all counters=0.
- Reset asserted mid-train: outputs go to 0 immediately, without waiting for a clock edge. No done is issued.
- Outputs: all driven directly from flops, so sig_out never glitches.
- States:
  - IDLE: sig_out=0, busy=0.
  - HIGH: sig_out=1, busy=1.
  - LOW: sig_out=0, busy=1.
- Accept condition: start=1 with state=IDLE and abort=0 at edge t0.
  - num_pulses is latched into the remaining-pulse counter.
  - The phase counter is loaded with HI_CYC-1.
  - State goes to HIGH, so sig_out=1 and busy=1 from cycle t0+1.
- HIGH: the phase counter decrements each cycle. At 0 the state goes to LOW and the counter loads LO_CYC-1. sig_out is high for exactly HI_CYC cycles.
- LOW: the phase counter decrements each cycle. At 0 the remaining-pulse counter decrements.
  - If pulses remain: state goes to HIGH and the counter reloads HI_CYC-1.
  - On the last pulse: state goes to IDLE, busy=0 and done=1 on the next cycle.
- Timing summary for N pulses accepted at t0:
  - Pulse k (k=0..N-1) is high during cycles t0+1+k*(HI_CYC+LO_CYC) through t0+k*(HI_CYC+LO_CYC)+HI_CYC.
  - busy is high during cycles t0+1 through t0+N*(HI_CYC+LO_CYC).
  - done is high for cycle t0+N*(HI_CYC+LO_CYC)+1 only.
- Zero count: start with num_pulses=0 in IDLE produces no pulses and busy stays 0. done=1 for the single cycle t0+1.
- start while busy: ignored entirely. The latched count is unaffected.
- start during the done cycle: legal, because the block is in IDLE. The new train's sig_out rises the next cycle, giving back-to-back trains.
- abort=1 at any edge while busy: next cycle state=IDLE, sig_out=0, busy=0. done is NOT asserted.
- abort=1 while IDLE: no effect.
- abort and start in the same cycle: abort wins and start is dropped.
- Counter behaviour: counters never wrap. The maximum train is (2^NUM_W - 1) pulses, 15 with defaults.
- Downstream edge_detect: it sees exactly N rising edges per train, because HI_CYC and LO_CYC are >=1 and sig_out is registered.

Test Plan:
1. Reset check: assert rst_n=0 mid-train (N=5, during a HIGH phase) -> sig_out, busy and done all 0 asynchronously. After release, the block stays in IDLE with no spurious pulse.
2. Single train: defaults, start with num_pulses=3 at t0.
   - sig_out high during t0+1..4, t0+9..12 and t0+17..20.
   - busy high during t0+1..24; done=1 only at t0+25.
   - A downstream edge_detect counts exactly 3 rise pulses.
3. Zero count: start with num_pulses=0 -> sig_out and busy stay 0, done=1 for the single cycle t0+1.
4. Abort: start with N=4, then assert abort at t0+6 (LOW phase of pulse 0).
   - sig_out=0 and busy=0 from t0+7.
   - done never asserted; exactly 1 rising edge emitted.
5. Ignored start and back-to-back trains:
   - start with N=2 at t0; a second start with N=7 at t0+3 is ignored, so done occurs at t0+17.
   - A start with N=1 at t0+17 is accepted: sig_out high during t0+18..21 and done at t0+26.
6. Abort/start collision: abort=1 and start=1 together in IDLE -> no train starts and busy stays 0. Also verify a max-count train (N=15) produces 15 rising edges with done at t0+121.

Source files
------------

// File: rtl/pulse_train_gen.sv
// Purpose: emits a train of N rectangular pulses (HI_CYC high, LO_CYC low) on a registered line.
// Latency: sig_out rises the cycle after an accepted start; done fires the cycle after the last low phase.
// Backpressure: none; start is dropped while busy or when abort is asserted, and abort cancels without done.
module pulse_train_gen #(
  parameter int HI_CYC = 4,
  parameter int LO_CYC = 4,
  parameter int CNT_W  = 8,
  parameter int NUM_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] num_pulses,
  input  logic             abort,
  output logic             sig_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  // Phase counters count down to zero, so they are loaded with length-1.
  localparam logic [CNT_W-1:0] HI_LOAD = CNT_W'(HI_CYC - 1);
  localparam logic [CNT_W-1:0] LO_LOAD = CNT_W'(LO_CYC - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   phase_q, phase_d;
  logic [NUM_W-1:0]   remain_q, remain_d;
  logic               sig_out_q, sig_out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Next-state, counter and output decode; outputs are derived from the next state so they can be registered.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    remain_d = remain_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // abort takes priority over a simultaneous start
        if (start && !abort) begin
          if (num_pulses == '0) begin
            // An empty train completes immediately with no pulses.
            done_d = 1'b1;
          end else begin
            state_d  = S_HIGH;
            phase_d  = HI_LOAD;
            remain_d = num_pulses;
          end
        end
      end

      S_HIGH: begin
        if (abort) begin
          state_d  = S_IDLE;
          phase_d  = '0;
          remain_d = '0;
        end else if (phase_q == '0) begin
          state_d = S_LOW;
          phase_d = LO_LOAD;
        end else begin
          phase_d = phase_q - CNT_W'(1);
        end
      end

      S_LOW: begin
        if (abort) begin
          state_d  = S_IDLE;
          phase_d  = '0;
          remain_d = '0;
        end else if (phase_q == '0) begin
          remain_d = remain_q - NUM_W'(1);
          if (remain_q == NUM_W'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_HIGH;
            phase_d = HI_LOAD;
          end
        end else begin
          phase_d = phase_q - CNT_W'(1);
        end
      end

      default: begin
        state_d  = S_IDLE;
        phase_d  = '0;
        remain_d = '0;
      end
    endcase

    sig_out_d = (state_d == S_HIGH);
    busy_d    = (state_d != S_IDLE);
  end

  // State, counters and output flops; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      remain_q  <= '0;
      sig_out_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      remain_q  <= remain_d;
      sig_out_q <= sig_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign sig_out = sig_out_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
